// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// byte-address to word-index conversion and the alignment check.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAP,
        RMW_RD,
        RMW_MERGE,
        WR_ISSUE,
        RESP
    } state_e;

    // Byte address to word index; the caller keeps only the bits the memory decodes.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

    function automatic logic access_bad(input size_e size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        unique case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Little-endian lane logic: pulls a byte/half/word out of a memory word with
// sign or zero extension, and merges store data into an existing word.
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            lo,
    input  size_e                 size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] ext_data,
    output logic [DATA_WIDTH-1:0] merged
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s   = word[{lo, 3'b000} +: 8];
        half_s   = word[{lo[1], 4'b0000} +: 16];
        ext_data = word;
        unique case (size)
            SZ_B: ext_data = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, byte_s}
                                         : {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            SZ_H: ext_data = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, half_s}
                                         : {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            default: ext_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        unique case (size)
            SZ_B:    merged[{lo, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    merged[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for a word-wide memory without byte enables: loads are
// lane-extracted, sub-word stores are done as read-modify-write.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 32,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [IDX_W-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    state_e                state, state_nxt;
    size_e                 size_q;
    logic                  uns_q;
    logic [1:0]            lo_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wword_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [IDX_W-1:0]      idx_q;

    logic                  accept;
    logic                  bad;
    logic [31:0]           widx;
    logic [DATA_WIDTH-1:0] lane_ext;
    logic [DATA_WIDTH-1:0] lane_merged;

    assign accept = req_valid & req_ready;
    assign bad    = access_bad(size_e'(req_size), req_addr[1:0]);
    assign widx   = word_index(32'(req_addr));

    dmem_lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .word        (mem_dout),
        .wdata       (wdata_q),
        .lo          (lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext_data    (lane_ext),
        .merged      (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (!RESET) begin
            state   <= IDLE;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            lo_q    <= 2'b00;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                size_q  <= size_e'(req_size);
                uns_q   <= req_unsigned;
                lo_q    <= req_addr[1:0];
                wdata_q <= req_wdata;
                wword_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= bad;
                idx_q   <= widx[IDX_W-1:0];
            end
            if (state == RD_CAP)
                rdata_q <= lane_ext;
            if (state == RMW_MERGE)
                wword_q <= lane_merged;
        end
    end

    // Strobes and handshake outputs are forced low while reset is held.
    always_comb begin
        state_nxt      = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (RESET) begin
            mem_addr       = idx_q;
            mem_write_data = wword_q;
            unique case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (bad)
                            state_nxt = RESP;
                        else if (!req_we)
                            state_nxt = RD_ISSUE;
                        else if (size_e'(req_size) == SZ_W)
                            state_nxt = WR_ISSUE;
                        else
                            state_nxt = RMW_RD;
                    end
                end
                RD_ISSUE: begin
                    mem_read  = 1'b1;
                    state_nxt = RD_CAP;
                end
                RD_CAP:    state_nxt = RESP;
                RMW_RD: begin
                    mem_read  = 1'b1;
                    state_nxt = RMW_MERGE;
                end
                RMW_MERGE: state_nxt = WR_ISSUE;
                WR_ISSUE: begin
                    mem_write = 1'b1;
                    state_nxt = RESP;
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready)
                        state_nxt = IDLE;
                end
                default:   state_nxt = IDLE;
            endcase
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a registered-read word memory model,
// a vector table for single transactions and hand-written corner sequences.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [9:0] cur_idx = '0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    dmem_lsu dut (
        .clk            (clk),
        .RESET          (RESET),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_dout       (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (mem_write)
            mem[mem_addr] <= mem_write_data;
        if (mem_read)
            mem_dout <= mem[mem_addr];
    end

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read || mem_write) begin
            checks++;
            if (mem_read && mem_write) begin
                errors++;
                $display("FAIL strobe_overlap: read=%0b write=%0b, required not both", mem_read, mem_write);
            end
            checks++;
            if (mem_addr !== cur_idx) begin
                errors++;
                $display("FAIL strobe_addr: got %0d, required %0d", mem_addr, cur_idx);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        cur_idx      = v.addr[11:2];
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int n;
        int rd0, wr0, exp_rd, exp_wr;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({nm, "_ready"}, 32'(req_ready), 32'd1);
        drive_req(v);
        rsp_ready = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({nm, "_latency"}, 32'(n), 32'(v.exp_lat));
        check({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({nm, "_err"}, 32'(rsp_err), 32'(v.exp_err));
        @(posedge clk); #1;
        check({nm, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        exp_rd = v.exp_err ? 0 : (!v.we ? 1 : (v.size == 2'b10 ? 0 : 1));
        exp_wr = v.exp_err ? 0 : (v.we ? 1 : 0);
        check({nm, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({nm, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n, rd0, wr0;
        vec_t v;

        //          we    size   uns   addr          wdata          exp_rdata      err  lat
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 2};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h11223344, 32'h0000_0000, 1'b0, 2};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'hFFFFFFA5, 32'h0000_0000, 1'b0, 4};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,        32'hFFFFFFA5, 1'b0, 3};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,        32'h000000A5, 1'b0, 3};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'h11A53344, 1'b0, 3};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h12348001, 32'h0000_0000, 1'b0, 4};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'h0,        32'hFFFF8001, 1'b0, 3};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0014, 32'h0,        32'h00007788, 1'b0, 3};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        32'h80017788, 1'b0, 3};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h00000033, 1'b0, 3};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,        32'h00000000, 1'b1, 1};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'hCAFEBABE, 32'h00000000, 1'b1, 1};
        vecs[14] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h00000000, 1'b1, 1};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 32'h0000_0017, 32'h0,        32'h00000080, 1'b0, 3};
        vecs[16] = '{1'b0, 2'b00, 1'b0, 32'h0000_0017, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0,        32'h11A53344, 1'b0, 3};

        RESET        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        pre_we       = 1'b1;
        pre_idx      = 10'd5;
        pre_data     = 32'h55667788;
        @(posedge clk); #1;
        pre_we = 1'b0;
        @(posedge clk); #1;

        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);

        RESET = 1'b1;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // Response backpressure, with a second request waiting behind it.
        v = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h11A53344, 1'b0, 3};
        drive_req(v);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        rd0 = rd_cnt;
        req_addr = 32'h0000_0014;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("bp_latency", 32'(n), 32'd3);
        rd0 = rd_cnt;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid_%0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_rdata_%0d", k), rsp_rdata, 32'h11A53344);
            check($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bp_no_new_read", 32'(rd_cnt - rd0), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rsp_done", 32'(rsp_valid), 32'd0);
        check("bp_next_ready", 32'(req_ready), 32'd1);
        cur_idx = 10'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("bp2_latency", 32'(n), 32'd3);
        check("bp2_rdata", rsp_rdata, 32'h80017788);
        @(posedge clk); #1;

        // Reset while a byte store sits in RMW_MERGE.
        wr0 = wr_cnt;
        v = '{1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h00000077, 32'h0, 1'b0, 4};
        drive_req(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        RESET = 1'b0;
        #1;
        check("mid_rst_write", 32'(mem_write), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        RESET = 1'b1;
        #1;
        check("mid_rst_rel_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check("mid_rst_rsp_after", 32'(rsp_valid), 32'd0);
        check("mid_rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("mid_rst_mem4", mem[4], 32'h11A53344);
        run_vec('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h11A53344, 1'b0, 3}, "post_rst_load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
